// File: rtl/serial_twos_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Walks the accepted word LSB-first: bits are copied up to and including the first 1, then inverted.
module serial_twos_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_sign_o,
  output logic [WIDTH-1:0] out_mag_o,
  output logic             out_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             sign_q, sign_d;
  logic             seen_q, seen_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             emit_bit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  // For positive words seen_one never gates inversion, so every bit passes straight through.
  assign emit_bit = (sign_q && seen_q) ? ~shift_q[0] : shift_q[0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          shift_d = in_data_i;
          sign_d  = in_data_i[WIDTH-1];
          seen_d  = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mag_d   = {emit_bit, mag_q[WIDTH-1:1]};
        shift_d = shift_q >> 1;
        seen_d  = seen_q | shift_q[0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_sign_o  = sign_q;
  assign out_mag_o   = mag_q;
  // Gated by DONE so the flag reads 0 out of reset, when mag_q is also 0.
  assign out_zero_o  = (state_q == DONE) && (mag_q == '0);

endmodule

// File: tb/tb_serial_twos_decoder.sv
// Directed-vector bench for serial_twos_decoder (WIDTH=4): table vectors, backpressure, reset abort, full sweep.
module tb_serial_twos_decoder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_zero;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int last_acc = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         sign;
    logic [W-1:0] mag;
    logic         zero;
  } vec_t;

  vec_t vecs [7];

  serial_twos_decoder #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sign_o  (out_sign),
    .out_mag_o   (out_mag),
    .out_zero_o  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one word through the block; hold = cycles of out_ready=0 after out_valid rises.
  task automatic convert(input logic [W-1:0] d, input logic es, input logic [W-1:0] em,
                         input logic ez, input int hold, input bit check_spacing);
    int lat;
    int acc;
    out_ready = (hold == 0);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    in_data  = '0;
    chk("in_ready_low_after_accept", in_ready, 0);
    if (check_spacing) chk("accept_spacing", acc - last_acc, W + 2);
    last_acc = acc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (!out_valid) chk("in_ready_low_in_shift", in_ready, 0);
    end
    chk("latency", lat, W);
    chk("out_sign", out_sign, es);
    chk("out_mag", out_mag, em);
    chk("out_zero", out_zero, ez);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_data  = ~d;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_sign", out_sign, es);
      chk("hold_mag", out_mag, em);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_drop_after_handshake", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
    $display("word %b -> sign=%b mag=%b zero=%b latency=%0d hold=%0d", d, out_sign, em, ez, lat, hold);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] neg;
    int wait_n;

    vecs[0] = '{4'b0101, 1'b0, 4'b0101, 1'b0};
    vecs[1] = '{4'b1011, 1'b1, 4'b0101, 1'b0};
    vecs[2] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
    vecs[3] = '{4'b1111, 1'b1, 4'b0001, 1'b0};
    vecs[4] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
    vecs[5] = '{4'b0111, 1'b0, 4'b0111, 1'b0};
    vecs[6] = '{4'b1001, 1'b1, 4'b0111, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sign", out_sign, 0);
    chk("reset_out_mag", out_mag, 0);
    chk("reset_out_zero", out_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      convert(vecs[i].data, vecs[i].sign, vecs[i].mag, vecs[i].zero, 0, 1'b0);
    end

    // Backpressure: three stalled cycles, handshake on the fourth.
    convert(4'b1110, 1'b1, 4'b0010, 1'b0, 3, 1'b0);

    // Reset two cycles into SHIFT aborts the conversion.
    in_valid = 1'b1;
    in_data  = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready_during_reset", in_ready, 1);
    chk("abort_out_valid_during_reset", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) wait_n++;
    end
    chk("abort_no_result", wait_n, 0);
    chk("abort_idle_after", in_ready, 1);
    $display("reset abort of 1001 -> out_valid pulses=%0d", wait_n);
    convert(4'b0011, 1'b0, 4'b0011, 1'b0, 0, 1'b0);

    // Reset wins over a simultaneous in_valid.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_wins_in_ready", in_ready, 1);
    chk("reset_wins_out_valid", out_valid, 0);
    $display("reset with in_valid -> in_ready=%b", in_ready);

    // Sweep all words back-to-back; expected values from integer negation.
    for (int v = 0; v < 16; v++) begin
      x   = v[W-1:0];
      neg = -x;
      convert(x, x[W-1], x[W-1] ? neg : x, (x == '0), 0, v != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
